h264nstore: RTL

Neighbour total-coefficient store for the inter encode path. Sits beside the CAVLC coder, driven by the inter coefficient buffer's NLOAD/NX/NY/NV/NXINC outputs. It records each 4x4 block's TotalCoeff (NOUT from CAVLC) and returns the nC predictor (NIN) for the block being coded from left and top neighbours. Left neighbours come from the current or previous macroblock; top neighbours come from the macroblock row above.

---
 rtl/h264nstore_pkg.sv | 17 +
 rtl/h264nstore_if.sv | 16 +
 rtl/h264nstore_ram.sv | 29 ++
 rtl/h264nstore.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/h264nstore_pkg.sv
// Shared types and encodings for the neighbour total-coefficient store.
package h264_pkg;

  // One TotalCoeff / nC value, range 0..16.
  typedef logic [4:0] nc_t;

  // Bit 2 of NX/NY selects luma or chroma block addressing.
  localparam logic NC_LUMA   = 1'b0;
  localparam logic NC_CHROMA = 1'b1;

  // Cr block (1,1): the last chroma block of a macroblock, which triggers the chroma commit.
  localparam logic [2:0] CHR_LAST = 3'b111;

  // Each top-row memory word is split into a luma half and a chroma half.
  localparam int ROWW = 20;

endpackage

// File: rtl/h264nstore_if.sv
// Block-address / coefficient-count bundle between the coefficient buffer and the store.
interface h264nstore_if;
  import h264_pkg::*;

  logic       NEWLINE;
  logic       NLOAD;
  logic [2:0] NX;
  logic [2:0] NY;
  logic [1:0] NV;
  logic       NXINC;
  nc_t        NOUT;
  nc_t        NIN;

  modport master (output NEWLINE, NLOAD, NX, NY, NV, NXINC, NOUT, input NIN);
  modport slave  (input NEWLINE, NLOAD, NX, NY, NV, NXINC, NOUT, output NIN);
endinterface

// File: rtl/h264nstore_ram.sv
// Top-row memory: one write port and one registered read port, with separate write enables for the two halves.
// A read of the word being written returns the old contents.
module h264nstore_ram #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 40,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [1:0]       we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  localparam int HW = WIDTH / 2;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write each half independently; the read is registered.
  always_ff @(posedge clk) begin
    if (we[0]) mem[waddr][HW-1:0]    <= wdata[HW-1:0];
    if (we[1]) mem[waddr][WIDTH-1:HW] <= wdata[WIDTH-1:HW];
    if (re)    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/h264nstore.sv
// Neighbour TotalCoeff store: keeps the current MB's counts, the left column and the top row, and produces the nC predictor.
module h264nstore import h264_pkg::*; #(
  parameter int MAXMBX = 128,
  parameter int MBXW   = $clog2(MAXMBX)
) (
  input logic         CLK,
  input logic         NEWSLICE,
  h264nstore_if.slave nb
);
  typedef logic [MBXW-1:0] mbx_t;

  nc_t  lum_q [16], lum_d [16], lum_w [16];    // luma cell index {y,x}
  nc_t  chr_q [8],  chr_d [8],  chr_w [8];     // chroma cell index {cr,y,x}
  nc_t  lum_l_q [4], lum_l_d [4];              // left luma, index y
  nc_t  chr_l_q [4], chr_l_d [4];              // left chroma, index {cr,y}
  nc_t  lum_t_q [4], lum_t_d [4];              // top luma, index x
  nc_t  chr_t_q [4], chr_t_d [4];              // top chroma, index {cr,x}
  mbx_t mbx_q, mbx_d, cmbx_q, cmbx_d, mbx_nxt;
  logic ld_lum_q, ld_lum_d, ld_chr_q, ld_chr_d;
  nc_t  nin_q, nin_d, nb_a, nb_b;
  logic [5:0] sum;

  logic       is_chr, cr, luma_commit, chr_commit, ram_re;
  logic [1:0] bx, by, ram_we;
  logic [2*ROWW-1:0] ram_wdata, ram_rdata;
  mbx_t ram_waddr, ram_raddr;

  // A block is chroma only when both coordinates carry the chroma tag.
  assign is_chr = (nb.NX[2] == NC_CHROMA) && (nb.NY[2] == NC_CHROMA);
  assign cr     = nb.NX[1];
  assign bx     = is_chr ? {1'b0, nb.NX[0]} : nb.NX[1:0];
  assign by     = is_chr ? {1'b0, nb.NY[0]} : nb.NY[1:0];

  assign luma_commit = nb.NXINC & ~NEWSLICE;
  assign chr_commit  = nb.NLOAD & (nb.NX == CHR_LAST) & (nb.NY == CHR_LAST) & ~NEWSLICE;
  assign mbx_nxt     = (mbx_q == mbx_t'(MAXMBX - 1)) ? '0 : mbx_q + 1'b1;

  // Cell arrays with this cycle's NOUT overlaid, so a commit in the same cycle never sees a stale cell.
  always_comb begin
    lum_w = lum_q;
    chr_w = chr_q;
    if (nb.NLOAD && !is_chr) lum_w[{by, bx}] = nb.NOUT;
    if (nb.NLOAD && is_chr)  chr_w[{cr, by[0], bx[0]}] = nb.NOUT;
  end

  // Top-row memory traffic: luma commits take the write port over chroma, NEWLINE takes the read port.
  assign ram_wdata = {chr_w[7], chr_w[6], chr_w[3], chr_w[2],
                      lum_w[15], lum_w[14], lum_w[13], lum_w[12]};
  assign ram_we    = {chr_commit & ~luma_commit, luma_commit};
  assign ram_waddr = luma_commit ? mbx_q : cmbx_q;
  assign ram_re    = ~NEWSLICE & (nb.NEWLINE | nb.NXINC | chr_commit);
  assign ram_raddr = nb.NEWLINE ? '0 : (nb.NXINC ? mbx_nxt : mbx_q);

  h264nstore_ram #(.DEPTH(MAXMBX), .WIDTH(2 * ROWW), .AW(MBXW)) u_ram (
    .clk   (CLK),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Pick left (A) and top (B) neighbours from the registered cells, then form nC.
  always_comb begin
    if (is_chr) begin
      nb_a = bx[0] ? chr_q[{cr, by[0], 1'b0}] : chr_l_q[{cr, by[0]}];
      nb_b = by[0] ? chr_q[{cr, 1'b0, bx[0]}] : chr_t_q[{cr, bx[0]}];
    end else begin
      nb_a = (bx != 2'd0) ? lum_q[{by, bx - 2'd1}] : lum_l_q[by];
      nb_b = (by != 2'd0) ? lum_q[{by - 2'd1, bx}] : lum_t_q[bx];
    end
    sum = {1'b0, nb_a} + {1'b0, nb_b} + 6'd1;
    case (nb.NV)
      2'd3:    nin_d = sum[5:1];
      2'd1:    nin_d = nb_a;
      2'd2:    nin_d = nb_b;
      default: nin_d = '0;
    endcase
  end

  // Next-state for cells, left/top registers, counters and prefetch-load flags.
  always_comb begin
    lum_d    = lum_w;
    chr_d    = chr_w;
    lum_l_d  = lum_l_q;
    chr_l_d  = chr_l_q;
    lum_t_d  = lum_t_q;
    chr_t_d  = chr_t_q;
    mbx_d    = mbx_q;
    cmbx_d   = cmbx_q;
    ld_lum_d = nb.NEWLINE | nb.NXINC;
    ld_chr_d = nb.NEWLINE | chr_commit;
    if (ld_lum_q) for (int x = 0; x < 4; x++) lum_t_d[x] = ram_rdata[5*x +: 5];
    if (ld_chr_q) for (int k = 0; k < 4; k++) chr_t_d[k] = ram_rdata[ROWW + 5*k +: 5];
    if (chr_commit) begin
      chr_l_d[0] = chr_w[1];
      chr_l_d[1] = chr_w[3];
      chr_l_d[2] = chr_w[5];
      chr_l_d[3] = chr_w[7];
    end
    if (nb.NXINC) begin
      for (int y = 0; y < 4; y++) lum_l_d[y] = lum_w[4*y + 3];
      cmbx_d = mbx_q;
      mbx_d  = mbx_nxt;
    end
    if (nb.NEWLINE) begin
      mbx_d   = '0;
      cmbx_d  = '0;
      lum_l_d = '{default: '0};
      chr_l_d = '{default: '0};
    end
  end

  // State registers; NEWSLICE clears everything and overrides all other controls.
  always_ff @(posedge CLK) begin
    if (NEWSLICE) begin
      lum_q    <= '{default: '0};
      chr_q    <= '{default: '0};
      lum_l_q  <= '{default: '0};
      chr_l_q  <= '{default: '0};
      lum_t_q  <= '{default: '0};
      chr_t_q  <= '{default: '0};
      mbx_q    <= '0;
      cmbx_q   <= '0;
      ld_lum_q <= 1'b0;
      ld_chr_q <= 1'b0;
      nin_q    <= '0;
    end else begin
      lum_q    <= lum_d;
      chr_q    <= chr_d;
      lum_l_q  <= lum_l_d;
      chr_l_q  <= chr_l_d;
      lum_t_q  <= lum_t_d;
      chr_t_q  <= chr_t_d;
      mbx_q    <= mbx_d;
      cmbx_q   <= cmbx_d;
      ld_lum_q <= ld_lum_d;
      ld_chr_q <= ld_chr_d;
      nin_q    <= nin_d;
    end
  end

  assign nb.NIN = nin_q;
endmodule
